uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter CW = log2(DEPTH)+1, derived, meaning width of the occupancy count.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-007 rd_en  input  1  CPU read strobe for the RX data address (io_enable bit 4 gated with a load).
REQ-008 clr_ovr  input  1  CPU write strobe that clears the overrun flag.
REQ-009 rd_data  output  32  read word: {24'hFFFFFF, head byte} when not empty, else 32'h0.
REQ-010 status  output  32  {16'h0, count zero-extended to 8 bits, 5'b0, ovr, full, ~empty}.
REQ-011 empty  output  1  count == 0.
REQ-012 full  output  1  count == DEPTH.
REQ-013 irq  output  1  level interrupt, asserted while ~empty or ovr is set.

Function
REQ-014 Storage SHALL be a circular buffer with DEPTH byte entries, write pointer wp, read pointer rp (each log2(DEPTH) bits, wrapping modulo DEPTH) and count (CW bits).
REQ-015 Push: rx_valid=1 with full=0 SHALL write rx_data at wp, then wp+1 and count+1 at the next edge.
REQ-016 Pop: rd_en=1 with empty=0 SHALL advance rp by 1 and decrement count at the next edge.
REQ-017 Read is first-word fall-through: rd_data SHALL combinationally reflect the entry at rp with zero cycles of latency, and the byte returned is the one present in the cycle rd_en is high.
REQ-018 rd_en while empty SHALL have no effect on state; rd_data SHALL read 32'h0 in that cycle.
REQ-019 Push while full with no simultaneous pop SHALL discard rx_data, leave wp, rp, count and the stored data unchanged, and set ovr=1 at the next edge.
REQ-020 Simultaneous push and pop when not empty SHALL advance both pointers and leave count unchanged; this holds when full, so no overrun occurs.
REQ-021 Simultaneous push and pop when empty: the pop SHALL be ignored, the push SHALL complete, count becomes 1, and rd_data SHALL be 32'h0 in that cycle.
REQ-022 ovr is sticky; clr_ovr=1 SHALL clear it at the next edge unless an overrun occurs in the same cycle, in which case ovr SHALL remain 1.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; full and empty SHALL be derived from count, never from pointer equality alone.
REQ-024 status, empty, full and irq SHALL be combinational from registered state and SHALL add no extra latency.
REQ-025 The block SHALL tolerate rx_valid asserted on consecutive cycles, accepting one byte per cycle.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear wp, rp, count and ovr.
REQ-027 While rst_n=0: empty=1, full=0, irq=0, rd_data=32'h0, status=32'h0.
REQ-028 Buffer contents need not be reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored bytes; a push or pop in that cycle SHALL be lost.
REQ-030 The first push SHALL be accepted on the first rising edge after rst_n returns high.

Verification
REQ-031 After reset, push 8'h41 -> next cycle rd_data=32'hFFFFFF41, status=32'h0000_0101, irq=1; pulse rd_en -> next cycle rd_data=0, empty=1, irq=0.
REQ-032 DEPTH=8: push 8'h00..8'h07, then push 8'hAA -> full=1, ovr=1, status=32'h0000_0807; pop 8 bytes -> bytes read are 00..07 in order and 8'hAA is never returned.
REQ-033 With 8 entries stored, push 8'h55 and pop in the same cycle -> count stays 8, ovr stays 0, and 8'h55 is read last after 7 further pops.
REQ-034 Empty FIFO, push 8'h33 and rd_en in the same cycle -> count=1, next rd_data=32'hFFFFFF33.
REQ-035 ovr=1, clr_ovr coincident with a push into the full FIFO -> ovr remains 1; clr_ovr alone the following cycle -> ovr=0, irq follows empty.
REQ-036 Run 20 push/pop cycles so both pointers wrap twice, then drop rst_n asynchronously mid-cycle -> outputs reach their reset values immediately; a push after release reads back correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with first-word fall-through read, sticky overrun flag and level IRQ.
// Zero-latency read of head byte; pushes into a full FIFO are dropped (overrun) unless a pop coincides.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rd_en,
  input  logic        clr_ovr,
  output logic [31:0] rd_data,
  output logic [31:0] status,
  output logic        empty,
  output logic        full,
  output logic        irq
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          ovr;

  logic          pop;
  logic          push;
  logic          overrun;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign pop     = rd_en && !empty;
  assign push    = rx_valid && (!full || pop);
  assign overrun = rx_valid && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Overrun wins over a coincident clear so a fresh loss is never hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if (overrun) begin
      ovr <= 1'b1;
    end else if (clr_ovr) begin
      ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= rx_data;
  end

  assign rd_data = empty ? 32'h0 : {24'hFFFFFF, mem[rp]};
  assign status  = {16'h0, 8'(count), 5'b0, ovr, full, ~empty};
  assign irq     = ~empty | ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: read words are scored by a negedge monitor against an expected queue.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_ovr = 1'b0;
  logic [31:0] rd_data;
  logic [31:0] status;
  logic        empty;
  logic        full;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [7:0]  mq [$];
  logic        ovr_m = 1'b0;

  uart_rx_fifo #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_en    (rd_en),
    .clr_ovr  (clr_ovr),
    .rd_data  (rd_data),
    .status   (status),
    .empty    (empty),
    .full     (full),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs are applied just after a rising edge and removed just after the next.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rd, input logic clr);
    logic pop_ok;
    logic acc;
    logic ovf;
    pop_ok = rd && (mq.size() > 0);
    if (rd) exp_q.push_back(pop_ok ? {24'hFFFFFF, mq[0]} : 32'h0);
    acc = v && ((mq.size() < 8) || pop_ok);
    ovf = v && (mq.size() == 8) && !pop_ok;
    if (pop_ok) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    if (ovf) ovr_m = 1'b1;
    else if (clr) ovr_m = 1'b0;
    rx_valid = v; rx_data = d; rd_en = rd; clr_ovr = clr;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_word unexpected read got=%h", rd_data);
      end else begin
        chk("rd_word", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_status", status, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte in and out
    cyc(1, 8'h41, 0, 0);
    chk("one_rd_data", rd_data, 32'hFFFFFF41);
    chk("one_status", status, 32'h0000_0101);
    chk("one_irq", 32'(irq), 32'h1);
    cyc(0, 8'h00, 1, 0);
    chk("pop_rd_data", rd_data, 32'h0);
    chk("pop_empty", 32'(empty), 32'h1);
    chk("pop_irq", 32'(irq), 32'h0);

    // Read while empty
    cyc(0, 8'h00, 1, 0);
    chk("empty_rd_status", status, 32'h0);

    // Fill, overflow, sticky overrun vs clear
    for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0);
    chk("fill_status", status, 32'h0000_0803);
    chk("fill_full", 32'(full), 32'h1);
    cyc(1, 8'hAA, 0, 0);
    chk("ovf_status", status, 32'h0000_0807);
    chk("ovf_rd_data", rd_data, 32'hFFFFFF00);
    cyc(1, 8'hAA, 0, 1);
    chk("ovf_clr_same", status, 32'h0000_0807);
    cyc(0, 8'h00, 0, 1);
    chk("clr_status", status, 32'h0000_0803);
    chk("clr_irq", 32'(irq), 32'h1);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
    chk("drain_status", status, 32'h0);
    chk("drain_irq", 32'(irq), 32'h0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    cyc(1, 8'h55, 1, 0);
    chk("full_pp_status", status, 32'h0000_0803);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0);
    chk("full_pp_head", rd_data, 32'hFFFFFF55);
    cyc(0, 8'h00, 1, 0);
    chk("full_pp_empty", 32'(empty), 32'h1);

    // Push and pop together while empty
    cyc(1, 8'h33, 1, 0);
    chk("empty_pp_status", status, 32'h0000_0101);
    chk("empty_pp_rd_data", rd_data, 32'hFFFFFF33);
    cyc(0, 8'h00, 1, 0);

    // Wrap both pointers twice, then reset mid-cycle
    cyc(1, 8'hC0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'hC1 + i), 1, 0);
    cyc(1, 8'hE0, 0, 0);
    chk("wrap_status", status, 32'h0000_0201);
    chk("wrap_rd_data", rd_data, 32'hFFFFFFD4);
    rx_valid = 1'b1; rx_data = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_full", 32'(full), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rd_data", rd_data, 32'h0);
    chk("arst_status", status, 32'h0);
    mq.delete();
    ovr_m = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rst_n = 1'b1;
    cyc(1, 8'h5A, 0, 0);
    chk("post_rst_rd_data", rd_data, 32'hFFFFFF5A);
    chk("post_rst_status", status, 32'h0000_0101);
    cyc(0, 8'h00, 1, 0);
    chk("post_rst_empty", 32'(empty), 32'h1);

    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("model_ovr", 32'(status[2]), 32'(ovr_m));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
